// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes "S<addr><data_hi><data_lo>" hex write commands from a UART byte stream
// and returns a 'K'/'?' ack byte. Define UART_CMD_PARSER_ECHO_EN to mirror RX bytes on TX ahead of acks.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter logic [7:0]  ACK_OK         = 8'h4B,
    parameter logic [7:0]  ACK_ERR        = 8'h3F
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       WR_EN,
    output logic [3:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       ERR,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY
);

    localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_RAW < 17) ? 17 : TW_RAW;
    // Timer reads k-1 on the k-th idle cycle after a byte, so this value makes ERR land TIMEOUT_CYCLES after it.
    localparam logic [TW-1:0] EXPIRE_AT = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_DATA_HI = 2'd2,
        ST_DATA_LO = 2'd3
    } state_t;

    function automatic logic f_is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    function automatic logic [3:0] f_hex_val(input logic [7:0] b);
        logic [7:0] t;
        if (b <= 8'h39) begin
            t = b - 8'h30;
        end else if (b >= 8'h61) begin
            t = b - 8'h57;
        end else begin
            t = b - 8'h37;
        end
        return t[3:0];
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_addr_sh;
    logic [3:0]      r_data_hi;
    logic            r_wr_en;
    logic [3:0]      r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_err;
    logic            r_ack_v;
    logic [7:0]      r_ack_d;
    logic            w_is_hex;
    logic [3:0]      w_nib;
    logic            w_is_s;
    logic            w_is_ws;
    logic            w_expire;
    logic            w_ok_ev;
    logic            w_err_ev;
    logic            w_ack_req;
    logic            w_ack_take;

    // Classify the incoming byte.
    always_comb begin
        w_is_hex = f_is_hex(RX_DATA);
        w_nib    = f_hex_val(RX_DATA);
        w_is_s   = (RX_DATA == 8'h53) || (RX_DATA == 8'h73);
        w_is_ws  = (RX_DATA == 8'h0D) || (RX_DATA == 8'h0A) || (RX_DATA == 8'h20);
    end

    assign w_expire = (r_state != ST_IDLE) && !RX_VALID && (r_timer == EXPIRE_AT);

    // Next-state and event decode; a byte always takes precedence over timer expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_ok_ev     = 1'b0;
        w_err_ev    = 1'b0;
        if (RX_VALID) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_s) begin
                        w_state_nxt = ST_ADDR;
                    end else if (w_is_ws) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_ev    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ADDR, ST_DATA_HI, ST_DATA_LO: begin
                    if (w_is_hex) begin
                        case (r_state)
                            ST_ADDR:    w_state_nxt = ST_DATA_HI;
                            ST_DATA_HI: w_state_nxt = ST_DATA_LO;
                            default:    w_state_nxt = ST_IDLE;
                        endcase
                        w_ok_ev = (r_state == ST_DATA_LO);
                    end else if (w_is_s) begin
                        w_err_ev    = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_err_ev    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_err_ev    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (w_expire) begin
            w_err_ev    = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Command FSM with inter-byte timer, nibble shadows and registered write/error strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_addr_sh <= 4'h0;
            r_data_hi <= 4'h0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 4'h0;
            r_wr_data <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_ok_ev;
            r_err   <= w_err_ev;
            if (RX_VALID || (r_state == ST_IDLE)) begin
                r_timer <= '0;
            end else if (r_timer != EXPIRE_AT) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= r_timer;
            end
            if (RX_VALID && w_is_hex) begin
                case (r_state)
                    ST_ADDR:    r_addr_sh <= w_nib;
                    ST_DATA_HI: r_data_hi <= w_nib;
                    ST_DATA_LO: begin
                        r_wr_addr <= r_addr_sh;
                        r_wr_data <= {r_data_hi, w_nib};
                    end
                    default: begin
                        r_addr_sh <= r_addr_sh;
                    end
                endcase
            end
        end
    end

    assign w_ack_req = w_ok_ev | w_err_ev;

`ifdef UART_CMD_PARSER_ECHO_EN
    logic       r_echo_v;
    logic [7:0] r_echo_d;
    logic       w_echo_take;

    assign w_echo_take = TX_READY & r_echo_v;
    assign w_ack_take  = TX_READY & r_ack_v & ~r_echo_v;

    // One-entry echo buffer; it owns TX whenever it holds a byte.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_echo_v <= 1'b0;
            r_echo_d <= 8'h00;
        end else if (RX_VALID && (!r_echo_v || w_echo_take)) begin
            r_echo_v <= 1'b1;
            r_echo_d <= RX_DATA;
        end else if (w_echo_take) begin
            r_echo_v <= 1'b0;
        end else begin
            r_echo_v <= r_echo_v;
        end
    end

    assign TX_VALID = r_echo_v | r_ack_v;
    assign TX_DATA  = r_echo_v ? r_echo_d : r_ack_d;
`else
    assign w_ack_take = TX_READY & r_ack_v;
    assign TX_VALID   = r_ack_v;
    assign TX_DATA    = r_ack_d;
`endif

    // One-entry ack buffer: a new ack is dropped while full unless the current one leaves this cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ack_v <= 1'b0;
            r_ack_d <= 8'h00;
        end else if (w_ack_req && (!r_ack_v || w_ack_take)) begin
            r_ack_v <= 1'b1;
            r_ack_d <= w_ok_ev ? ACK_OK : ACK_ERR;
        end else if (w_ack_take) begin
            r_ack_v <= 1'b0;
        end else begin
            r_ack_v <= r_ack_v;
        end
    end

    assign WR_EN   = r_wr_en;
    assign WR_ADDR = r_wr_addr;
    assign WR_DATA = r_wr_data;
    assign ERR     = r_err;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-stream command decoder that sits directly downstream of the UART receiver in the 12 MHz iCE40 design. It consumes received bytes and decodes ASCII write commands of the form 'S' + 1 hex address nibble + 2 hex data nibbles, e.g. "S0F7" (addr 0x0, data 0xF7) or "S014" (addr 0x0, data 0x14). Each valid command produces a one-cycle register-write strobe. An acknowledge byte is returned toward the UART transmitter.

Parameters:
TIMEOUT_CYCLES, 120000, max CLK cycles allowed between bytes inside a command (10 ms at 12 MHz); 17-bit counter minimum
ACK_OK, 8'h4B, ack byte for a successful write ('K')
ACK_ERR, 8'h3F, ack byte for a rejected command ('?')

Ports:
CLK  input  1  system clock, 12 MHz
RST_N  input  1  asynchronous active-low reset
RX_DATA  input  8  byte from UART receiver, valid only while RX_VALID=1
RX_VALID  input  1  single-cycle strobe, one per received byte
WR_EN  output  1  single-cycle write strobe
WR_ADDR  output  4  write address, held until next write
WR_DATA  output  8  write data, held until next write
ERR  output  1  single-cycle strobe on any rejected or aborted command
TX_DATA  output  8  ack byte to UART transmitter
TX_VALID  output  1  ack pending; held until accepted
TX_READY  input  1  transmitter accepts TX_DATA when TX_VALID&TX_READY

Behaviour:
- Reset: asynchronous on RST_N low. All outputs 0, state IDLE, timer 0, ack buffer empty. Reset mid-command discards the partial command with no WR_EN and no ERR.
- FSM states: IDLE, ADDR, DATA_HI, DATA_LO. State advances only on RX_VALID.
- IDLE: 'S'/'s' -> ADDR. CR (0x0D), LF (0x0A), space (0x20) are ignored. Any other byte -> ERR pulse, ack ACK_ERR, remain IDLE.
- ADDR: hex digit (0-9, A-F, a-f) -> latch nibble into the address shadow, go to DATA_HI.
- DATA_HI: hex digit -> latch the upper data nibble, go to DATA_LO.
- DATA_LO: hex digit -> latch the lower data nibble, go to IDLE.
- On a valid DATA_LO byte at cycle n:
  - WR_EN=1 at cycle n+1 for exactly one cycle.
  - WR_ADDR/WR_DATA update at cycle n+1 and then hold.
  - ACK_OK is queued.
- In ADDR/DATA_HI/DATA_LO:
  - 'S'/'s' -> ERR pulse, ack ACK_ERR, resynchronise to ADDR (new command starts).
  - Any other non-hex byte -> ERR pulse, ack ACK_ERR, go to IDLE.
- Timeout:
  - Timer clears on every RX_VALID and runs only in non-IDLE states.
  - Reaching TIMEOUT_CYCLES without RX_VALID -> ERR pulse, ack ACK_ERR, go to IDLE.
  - If RX_VALID and expiry coincide, RX_VALID wins and no timeout occurs.
- ERR is registered and asserts one cycle after the offending byte or expiry.
- Ack buffer:
  - One entry. A queued ack sets TX_VALID=1 one cycle after the triggering byte.
  - TX_VALID clears the cycle after TX_VALID&TX_READY.
  - A new ack while the buffer is full is dropped; the pending ack is unchanged.
  - A new ack on the same cycle as acceptance is loaded, so TX_VALID stays 1 with the new data.
- Hex decode is case-insensitive. Arithmetic: data = {hi_nibble, lo_nibble}.

Optional Feature:
UART_CMD_PARSER_ECHO_EN
- Defined: every RX byte is also mirrored into a second one-entry echo buffer.
  - The echo buffer has priority on TX over the ack buffer, so the ack follows the echoed byte.
  - An echo is dropped if the echo buffer is full.
- Undefined: no echo logic; TX carries acks only.

Test Plan:
- Send "S0F7" at 115200 baud-spaced strobes -> one WR_EN pulse with WR_ADDR=0x0, WR_DATA=0xF7; TX_DATA=0x4B; ERR never asserted.
- Send "s3a5\n" -> WR_ADDR=0x3, WR_DATA=0xA5, one 'K' ack; the LF is ignored with no ERR.
- Send "S0G1" -> ERR pulse one cycle after 'G', no WR_EN, ack 0x3F. The trailing '1' in IDLE gives a second ERR; its ack is dropped if the first is still pending with TX_READY=0.
- Send "S01", then idle TIMEOUT_CYCLES -> ERR pulse exactly TIMEOUT_CYCLES cycles after the '1' strobe, FSM in IDLE. A following "S014" then writes addr 0x0, data 0x14.
- Hold TX_READY=0 and send "S0F7" then "S014" -> two WR_EN pulses; TX_VALID=1 with 0x4B; the second ack is dropped. Raising TX_READY yields exactly one handshake.
- Drive RST_N low after "S0F" -> outputs 0 immediately. After release, "7" alone gives ERR (IDLE) and no WR_EN.
